match_controller: RTL and testbench

Round/match sequencer sitting between the controller inputs and the game core. It gates player input through play_enable and pulses game_reset to re-initialise the core at each round start. It judges KO, time-out and draw from the core's health outputs, and tracks round wins. Its timer, round and winner outputs drive the HUD in vga_bitchange.

---
 rtl/match_controller.sv | 184 ++++++++++++++++++
 tb/tb_match_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// Round/match sequencer: countdown, fight, round-end hold and match-over phases,
// gating player input and pulsing game_reset at each round start.
module match_controller #(
   parameter int FRAMES_PER_SEC    = 60,
   parameter int ROUND_SECONDS     = 99,
   parameter int COUNTDOWN_SECONDS = 3,
   parameter int END_HOLD_SECONDS  = 2,
   parameter int ROUNDS_TO_WIN     = 2,
   parameter int MAX_ROUNDS        = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start,
   input  logic [7:0] p1_health,
   input  logic [7:0] p2_health,
   output logic       game_reset,
   output logic       play_enable,
   output logic [2:0] state,
   output logic [6:0] round_timer,
   output logic [1:0] countdown,
   output logic [2:0] round_num,
   output logic [1:0] p1_rounds,
   output logic [1:0] p2_rounds,
   output logic [1:0] round_result,
   output logic [1:0] winner
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_COUNTDOWN  = 3'd1,
      S_FIGHT      = 3'd2,
      S_ROUND_END  = 3'd3,
      S_MATCH_OVER = 3'd4
   } state_t;

   localparam int FCW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_SEC - 1);
   localparam logic [7:0]     HOLD_LAST  = 8'(END_HOLD_SECONDS - 1);

   state_t         state_r;
   state_t         next_state_s;
   logic [FCW-1:0] frame_cnt_r;
   logic [7:0]     hold_cnt_r;
   logic           start_q_r;
   logic           start_rise_s;
   logic           sec_tick_s;
   logic           transition_s;
   logic           enter_cd_s;
   logic [1:0]     fight_result_s;
   logic [1:0]     match_winner_s;

   // Larger value wins (1 = first, 2 = second), equal is a draw (3).
   function automatic logic [1:0] compare_pair(input logic [7:0] a, input logic [7:0] b);
      if (a > b)      return 2'd1;
      else if (b > a) return 2'd2;
      else            return 2'd3;
   endfunction

   assign state        = state_r;
   assign start_rise_s = start & ~start_q_r;
   assign sec_tick_s   = frame_tick && (frame_cnt_r == FRAME_LAST);
   assign transition_s = (next_state_s != state_r);
   assign enter_cd_s   = (next_state_s == S_COUNTDOWN) && (state_r != S_COUNTDOWN);

   // Next-state decode plus round and match outcome judgement.
   always_comb begin
      next_state_s   = state_r;
      fight_result_s = 2'd0;
      match_winner_s = 2'd0;
      case (state_r)
         S_IDLE: begin
            if (start_rise_s) next_state_s = S_COUNTDOWN;
            else              next_state_s = S_IDLE;
         end
         S_COUNTDOWN: begin
            if (sec_tick_s && countdown == 2'd1) next_state_s = S_FIGHT;
            else                                 next_state_s = S_COUNTDOWN;
         end
         S_FIGHT: begin
            if (p1_health == 8'd0 && p2_health == 8'd0) fight_result_s = 2'd3;
            else if (p2_health == 8'd0)                 fight_result_s = 2'd1;
            else if (p1_health == 8'd0)                 fight_result_s = 2'd2;
            else if (round_timer == 7'd0)               fight_result_s = compare_pair(p1_health, p2_health);
            else                                        fight_result_s = 2'd0;
            if (fight_result_s != 2'd0) next_state_s = S_ROUND_END;
            else                        next_state_s = S_FIGHT;
         end
         S_ROUND_END: begin
            if (sec_tick_s && hold_cnt_r == HOLD_LAST) begin
               if (p1_rounds == 2'(ROUNDS_TO_WIN)) begin
                  next_state_s   = S_MATCH_OVER;
                  match_winner_s = 2'd1;
               end else if (p2_rounds == 2'(ROUNDS_TO_WIN)) begin
                  next_state_s   = S_MATCH_OVER;
                  match_winner_s = 2'd2;
               end else if (round_num == 3'(MAX_ROUNDS)) begin
                  next_state_s   = S_MATCH_OVER;
                  match_winner_s = compare_pair({6'd0, p1_rounds}, {6'd0, p2_rounds});
               end else begin
                  next_state_s   = S_COUNTDOWN;
               end
            end else begin
               next_state_s = S_ROUND_END;
            end
         end
         S_MATCH_OVER: begin
            if (start_rise_s) next_state_s = S_IDLE;
            else              next_state_s = S_MATCH_OVER;
         end
         default: next_state_s = S_IDLE;
      endcase
   end

   // State, timers, round bookkeeping and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= S_IDLE;
         frame_cnt_r  <= {FCW{1'b0}};
         hold_cnt_r   <= 8'd0;
         start_q_r    <= 1'b0;
         game_reset   <= 1'b0;
         play_enable  <= 1'b0;
         round_timer  <= 7'(ROUND_SECONDS);
         countdown    <= 2'd0;
         round_num    <= 3'd1;
         p1_rounds    <= 2'd0;
         p2_rounds    <= 2'd0;
         round_result <= 2'd0;
         winner       <= 2'd0;
      end else begin
         start_q_r   <= start;
         state_r     <= next_state_s;
         game_reset  <= enter_cd_s;
         play_enable <= (next_state_s == S_FIGHT);

         // A frame_tick coinciding with a state change is dropped with the count.
         if (transition_s)
            frame_cnt_r <= {FCW{1'b0}};
         else if (frame_tick)
            frame_cnt_r <= (frame_cnt_r == FRAME_LAST) ? {FCW{1'b0}} : frame_cnt_r + FCW'(1);

         case (state_r)
            S_IDLE: begin
               if (transition_s) begin
                  p1_rounds    <= 2'd0;
                  p2_rounds    <= 2'd0;
                  round_result <= 2'd0;
                  winner       <= 2'd0;
                  round_num    <= 3'd1;
               end
            end
            S_COUNTDOWN: begin
               if (sec_tick_s) countdown <= countdown - 2'd1;
            end
            S_FIGHT: begin
               if (transition_s) begin
                  round_result <= fight_result_s;
                  hold_cnt_r   <= 8'd0;
                  if (fight_result_s == 2'd1 && p1_rounds != 2'd3) p1_rounds <= p1_rounds + 2'd1;
                  if (fight_result_s == 2'd2 && p2_rounds != 2'd3) p2_rounds <= p2_rounds + 2'd1;
               end else if (sec_tick_s && round_timer != 7'd0) begin
                  round_timer <= round_timer - 7'd1;
               end
            end
            S_ROUND_END: begin
               if (next_state_s == S_MATCH_OVER)     winner     <= match_winner_s;
               else if (next_state_s == S_COUNTDOWN) round_num  <= round_num + 3'd1;
               else if (sec_tick_s)                  hold_cnt_r <= hold_cnt_r + 8'd1;
            end
            S_MATCH_OVER: begin
            end
            default: begin
            end
         endcase

         if (enter_cd_s) begin
            countdown   <= 2'(COUNTDOWN_SECONDS);
            round_timer <= 7'(ROUND_SECONDS);
         end
      end
   end

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller: expectations are queued with each stimulus
// step and drained against the DUT outputs after the step's clock edges.
module tb_match_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick;
   logic       start;
   logic [7:0] p1_health;
   logic [7:0] p2_health;
   logic       game_reset;
   logic       play_enable;
   logic [2:0] state;
   logic [6:0] round_timer;
   logic [1:0] countdown;
   logic [2:0] round_num;
   logic [1:0] p1_rounds;
   logic [1:0] p2_rounds;
   logic [1:0] round_result;
   logic [1:0] winner;

   typedef struct {
      string       tag;
      logic [31:0] value;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   match_controller #(
      .FRAMES_PER_SEC(2), .ROUND_SECONDS(5), .COUNTDOWN_SECONDS(3),
      .END_HOLD_SECONDS(1), .ROUNDS_TO_WIN(2), .MAX_ROUNDS(3)
   ) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
      .p1_health(p1_health), .p2_health(p2_health),
      .game_reset(game_reset), .play_enable(play_enable), .state(state),
      .round_timer(round_timer), .countdown(countdown), .round_num(round_num),
      .p1_rounds(p1_rounds), .p2_rounds(p2_rounds),
      .round_result(round_result), .winner(winner)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic push_exp(input string tag, input logic [31:0] value);
      sb.push_back('{tag, value});
   endtask

   function automatic logic [31:0] observe(input string tag);
      case (tag)
         "state":        return {29'd0, state};
         "game_reset":   return {31'd0, game_reset};
         "play_enable":  return {31'd0, play_enable};
         "round_timer":  return {25'd0, round_timer};
         "countdown":    return {30'd0, countdown};
         "round_num":    return {29'd0, round_num};
         "p1_rounds":    return {30'd0, p1_rounds};
         "p2_rounds":    return {30'd0, p2_rounds};
         "round_result": return {30'd0, round_result};
         "winner":       return {30'd0, winner};
         default:        return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic drain();
      exp_t        e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.tag);
         checks++;
         assert (obs === e.value) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.value);
         end
      end
   endtask

   task automatic push_reset_values();
      push_exp("state", 0);       push_exp("game_reset", 0);  push_exp("play_enable", 0);
      push_exp("round_timer", 5); push_exp("countdown", 0);   push_exp("round_num", 1);
      push_exp("p1_rounds", 0);   push_exp("p2_rounds", 0);   push_exp("round_result", 0);
      push_exp("winner", 0);
   endtask

   initial begin
      reset = 1'b1; frame_tick = 1'b0; start = 1'b0;
      p1_health = 8'd100; p2_health = 8'd100;
      tick(); tick();
      push_reset_values(); drain();
      reset = 1'b0; tick();

      // Match 1, round 1: start pulse, countdown, KO of player 2
      start = 1'b1;
      push_exp("state", 1); push_exp("game_reset", 1); push_exp("countdown", 3);
      push_exp("round_timer", 5); push_exp("round_num", 1);
      tick(); drain();
      push_exp("game_reset", 0); push_exp("state", 1);
      tick(); drain();
      start = 1'b0;
      push_exp("countdown", 2); frames(2); drain();
      push_exp("countdown", 1); frames(2); drain();
      push_exp("countdown", 1); push_exp("state", 1); frame(); drain();
      push_exp("countdown", 0); push_exp("state", 2); push_exp("play_enable", 1); frame(); drain();
      p2_health = 8'd0;
      push_exp("state", 3); push_exp("round_result", 1); push_exp("p1_rounds", 1);
      push_exp("p2_rounds", 0); push_exp("play_enable", 0);
      tick(); drain();
      p2_health = 8'd100;
      frame();
      push_exp("state", 1); push_exp("game_reset", 1); push_exp("round_num", 2);
      push_exp("countdown", 3); push_exp("round_timer", 5);
      frame_tick = 1'b1; tick(); frame_tick = 1'b0; drain();
      push_exp("game_reset", 0); tick(); drain();

      // Round 2: equal health to time-out, draw
      push_exp("state", 2); frames(6); drain();
      p1_health = 8'd50; p2_health = 8'd50;
      push_exp("round_timer", 1); push_exp("state", 2); frames(9); drain();
      push_exp("round_timer", 0); push_exp("state", 3); push_exp("round_result", 3);
      push_exp("p1_rounds", 1); push_exp("p2_rounds", 0);
      frame(); drain();
      p1_health = 8'd100; p2_health = 8'd100;
      push_exp("state", 1); push_exp("round_num", 3); frames(2); drain();

      // Round 3: time-out with 60/40, P1 takes the match
      push_exp("state", 2); frames(6); drain();
      p1_health = 8'd60; p2_health = 8'd40;
      push_exp("state", 3); push_exp("round_result", 1); push_exp("p1_rounds", 2);
      frames(10); drain();
      start = 1'b1;
      push_exp("state", 3); tick(); drain();
      push_exp("state", 4); push_exp("winner", 1); frames(2); drain();
      push_exp("state", 4); tick(); tick(); drain();
      start = 1'b0; tick();
      start = 1'b1;
      push_exp("state", 0); push_exp("winner", 1); tick(); drain();
      start = 1'b0; tick();

      // Match 2: every round drawn, match ends at the round cap
      p1_health = 8'd100; p2_health = 8'd100;
      start = 1'b1;
      push_exp("state", 1); push_exp("game_reset", 1); push_exp("p1_rounds", 0);
      push_exp("round_result", 0); push_exp("winner", 0); push_exp("round_num", 1);
      tick(); drain();
      start = 1'b0;
      for (int rnd = 1; rnd <= 3; rnd++) begin
         push_exp("state", 2); push_exp("play_enable", 1); frames(6); drain();
         if (rnd == 2) begin
            p1_health = 8'd50; p2_health = 8'd50;
            push_exp("state", 3); push_exp("round_result", 3); frames(10); drain();
         end else begin
            p1_health = 8'd0; p2_health = 8'd0;
            push_exp("state", 3); push_exp("round_result", 3); push_exp("play_enable", 0);
            tick(); drain();
         end
         p1_health = 8'd100; p2_health = 8'd100;
         if (rnd < 3) begin
            push_exp("state", 1); push_exp("round_num", rnd + 1); frames(2); drain();
         end
      end
      push_exp("state", 4); push_exp("winner", 3); push_exp("round_num", 3);
      push_exp("p1_rounds", 0); push_exp("p2_rounds", 0);
      frames(2); drain();

      // Reset in the middle of a fight
      start = 1'b1; tick(); start = 1'b0; tick();
      start = 1'b1;
      push_exp("state", 1); tick(); drain();
      start = 1'b0;
      push_exp("state", 2); frames(6); drain();
      push_exp("round_timer", 3); push_exp("state", 2); frames(4); drain();
      reset = 1'b1;
      push_reset_values(); tick(); drain();
      reset = 1'b0;
      push_exp("state", 0); push_exp("game_reset", 0); tick(); drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
